// File: rtl/wpawn_promo_ctrl.sv
// White-pawn position/promotion controller feeding the pawn sprite renderer.
// Optional menu timeout (auto-queen) is enabled by defining WPAWN_PROMO_TIMEOUT_EN.
module wpawn_promo_ctrl #(
  parameter int unsigned INIT_COL       = 0,
  parameter int unsigned INIT_ROW       = 6,
  parameter int unsigned BOARD_X0       = 100,
  parameter int unsigned BOARD_Y0       = 20,
  parameter int unsigned SQ             = 55,
  parameter int unsigned BLINK_FRAMES   = 15,
  parameter int unsigned TIMEOUT_FRAMES = 600
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       pawn_move_valid,
  input  logic [2:0] pawn_col,
  input  logic [2:0] pawn_row,
  input  logic       pawn_captured,
  input  logic       key_valid,
  input  logic [7:0] keycode,
  output logic [9:0] offsetX,
  output logic [9:0] offsetY,
  output logic [2:0] promotion,
  output logic       promo_active,
  output logic [2:0] cursor,
  output logic       cursor_blink,
  output logic       promo_done,
  output logic       pawn_alive
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MENU     = 2'd1,
    S_PROMOTED = 2'd2,
    S_DEAD     = 2'd3
  } state_e;

  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  localparam logic [2:0] PIECE_PAWN  = 3'd0;
  localparam logic [2:0] PIECE_QUEEN = 3'd1;
  localparam logic [2:0] PIECE_LAST  = 3'd4;

  localparam logic [9:0] OFFX_RST = 10'(BOARD_X0 + INIT_COL * SQ);
  localparam logic [9:0] OFFY_RST = 10'(BOARD_Y0 + INIT_ROW * SQ);

  // Blink and timeout counters share one width, at least 10 bits.
  localparam int unsigned MAX_FRAMES = (BLINK_FRAMES > TIMEOUT_FRAMES) ? BLINK_FRAMES : TIMEOUT_FRAMES;
  localparam int unsigned CNT_W      = ($clog2(MAX_FRAMES) > 10) ? $clog2(MAX_FRAMES) : 10;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  state_e           state_q, state_d;
  logic             vsync_q;
  logic [9:0]       offx_q, offx_d;
  logic [9:0]       offy_q, offy_d;
  logic [2:0]       promo_q, promo_d;
  logic [2:0]       cursor_q, cursor_d;
  logic             active_q, active_d;
  logic             blink_q, blink_d;
  logic             done_q, done_d;
  logic             alive_q, alive_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;

  logic       tick;
  logic       key_right;
  logic       key_left;
  logic       key_enter;
  logic       menu_enter;
  logic       timeout;
  logic [9:0] move_x;
  logic [9:0] move_y;

  assign tick      = vsync_q & ~vsync;
  assign key_right = key_valid & (keycode == KEY_RIGHT);
  assign key_left  = key_valid & (keycode == KEY_LEFT);
  assign key_enter = key_valid & (keycode == KEY_ENTER);

  assign move_x = 10'(BOARD_X0) + 10'(pawn_col) * 10'(SQ);
  assign move_y = 10'(BOARD_Y0) + 10'(pawn_row) * 10'(SQ);

  assign menu_enter = (state_q == S_IDLE) & pawn_move_valid & ~pawn_captured &
                      (pawn_row == 3'd0) & (promo_q == PIECE_PAWN);

`ifdef WPAWN_PROMO_TIMEOUT_EN
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  assign timeout = tick & (frame_cnt_q == CNT_W'(TIMEOUT_FRAMES - 1));

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (menu_enter) begin
      frame_cnt_d = '0;
    end else if ((state_q == S_MENU) && tick) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    offx_d      = offx_q;
    offy_d      = offy_q;
    promo_d     = promo_q;
    cursor_d    = cursor_q;
    active_d    = active_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    alive_d     = alive_q;
    done_d      = 1'b0;

    // Capture overrides everything else in the cycle, including a pending enter.
    if (pawn_captured) begin
      state_d  = S_DEAD;
      alive_d  = 1'b0;
      active_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pawn_move_valid) begin
            offx_d = move_x;
            offy_d = move_y;
            if (menu_enter) begin
              state_d     = S_MENU;
              active_d    = 1'b1;
              cursor_d    = PIECE_QUEEN;
              blink_d     = 1'b1;
              blink_cnt_d = '0;
            end
          end
        end

        S_MENU: begin
          if (key_enter) begin
            state_d  = S_PROMOTED;
            promo_d  = cursor_q;
            active_d = 1'b0;
            blink_d  = 1'b0;
            done_d   = 1'b1;
          end else if (timeout) begin
            state_d  = S_PROMOTED;
            promo_d  = PIECE_QUEEN;
            active_d = 1'b0;
            blink_d  = 1'b0;
            done_d   = 1'b1;
          end else begin
            if (key_right) begin
              cursor_d = (cursor_q == PIECE_LAST) ? PIECE_QUEEN : cursor_q + 3'd1;
            end else if (key_left) begin
              cursor_d = (cursor_q == PIECE_QUEEN) ? PIECE_LAST : cursor_q - 3'd1;
            end
            if (tick) begin
              if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
              end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
              end
            end
          end
        end

        S_PROMOTED: begin
          if (pawn_move_valid) begin
            offx_d = move_x;
            offy_d = move_y;
          end
        end

        S_DEAD: begin
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      vsync_q     <= 1'b1;
      offx_q      <= OFFX_RST;
      offy_q      <= OFFY_RST;
      promo_q     <= PIECE_PAWN;
      cursor_q    <= PIECE_QUEEN;
      active_q    <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      done_q      <= 1'b0;
      alive_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      offx_q      <= offx_d;
      offy_q      <= offy_d;
      promo_q     <= promo_d;
      cursor_q    <= cursor_d;
      active_q    <= active_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      done_q      <= done_d;
      alive_q     <= alive_d;
    end
  end

  assign offsetX      = offx_q;
  assign offsetY      = offy_q;
  assign promotion    = promo_q;
  assign promo_active = active_q;
  assign cursor       = cursor_q;
  assign cursor_blink = blink_q;
  assign promo_done   = done_q;
  assign pawn_alive   = alive_q;

endmodule

// File: tb/tb_wpawn_promo_ctrl.sv
// Self-checking bench for wpawn_promo_ctrl: directed scenarios plus random
// stimulus against a behavioural model of the pawn/menu rules.
module tb_wpawn_promo_ctrl;

  localparam int BX   = 100;
  localparam int BY   = 20;
  localparam int SQP  = 55;
  localparam int BF   = 15;
  localparam int TO   = 4;
  localparam int ICOL = 3;
  localparam int IROW = 6;
`ifdef WPAWN_PROMO_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_MENU = 1, M_PROMOTED = 2, M_DEAD = 3;
  localparam logic [7:0] K_R = 8'h4F, K_L = 8'h50, K_E = 8'h28;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vsync = 1'b1;
  logic       pawn_move_valid = 1'b0;
  logic [2:0] pawn_col = 3'd0;
  logic [2:0] pawn_row = 3'd0;
  logic       pawn_captured = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] offsetX, offsetY;
  logic [2:0] promotion, cursor;
  logic       promo_active, cursor_blink, promo_done, pawn_alive;

  int checks = 0;
  int failures = 0;
  int tx = 0;

  // Behavioural model state
  int m_mode, m_col, m_row, m_promo, m_cursor, m_ticks;
  bit m_alive, m_done, m_vs_prev;

  wpawn_promo_ctrl #(
    .INIT_COL(ICOL),
    .TIMEOUT_FRAMES(TO)
  ) dut (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .vsync(vsync),
    .pawn_move_valid(pawn_move_valid),
    .pawn_col(pawn_col),
    .pawn_row(pawn_row),
    .pawn_captured(pawn_captured),
    .key_valid(key_valid),
    .keycode(keycode),
    .offsetX(offsetX),
    .offsetY(offsetY),
    .promotion(promotion),
    .promo_active(promo_active),
    .cursor(cursor),
    .cursor_blink(cursor_blink),
    .promo_done(promo_done),
    .pawn_alive(pawn_alive)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic int exp_x();
    return BX + m_col * SQP;
  endfunction

  function automatic int exp_y();
    return BY + m_row * SQP;
  endfunction

  // Highlight starts on at menu entry and flips every BF frames.
  function automatic bit exp_blink();
    if (m_mode == M_MENU) return ((m_ticks / BF) % 2) == 0;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_col = ICOL; m_row = IROW; m_promo = 0; m_cursor = 1;
    m_ticks = 0; m_alive = 1'b1; m_done = 1'b0; m_vs_prev = 1'b1;
  endtask

  task automatic model_step(input bit mv, input int col, input int row, input bit cap,
                            input bit kv, input logic [7:0] kc, input bit vs);
    bit tick;
    bit enter;
    tick = m_vs_prev && !vs;
    m_vs_prev = vs;
    m_done = 1'b0;
    enter = kv && (kc == K_E);
    if (cap) begin
      m_alive = 1'b0;
      m_mode = M_DEAD;
    end else if (m_mode == M_IDLE) begin
      if (mv) begin
        m_col = col; m_row = row;
        if (row == 0 && m_promo == 0) begin
          m_mode = M_MENU; m_cursor = 1; m_ticks = 0;
        end
      end
    end else if (m_mode == M_MENU) begin
      if (enter) begin
        m_promo = m_cursor; m_done = 1'b1; m_mode = M_PROMOTED;
      end else if (TIMEOUT_ON && tick && (m_ticks + 1 == TO)) begin
        m_promo = 1; m_done = 1'b1; m_mode = M_PROMOTED;
      end else begin
        if (kv && kc == K_R) m_cursor = (m_cursor % 4) + 1;
        if (kv && kc == K_L) m_cursor = ((m_cursor + 2) % 4) + 1;
        if (tick) m_ticks++;
      end
    end else if (m_mode == M_PROMOTED) begin
      if (mv) begin
        m_col = col; m_row = row;
      end
    end
  endtask

  // Drives one cycle of inputs, advances the model, leaves pulses deasserted.
  task automatic apply(input bit mv, input int col, input int row, input bit cap,
                       input bit kv, input logic [7:0] kc, input bit vs);
    pawn_move_valid = mv;
    pawn_col = 3'(col);
    pawn_row = 3'(row);
    pawn_captured = cap;
    key_valid = kv;
    keycode = kc;
    vsync = vs;
    @(posedge vga_clk);
    #1;
    model_step(mv, col, row, cap, kv, kc, vs);
    tx++;
    $display("tx %0d mv=%0d(%0d,%0d) cap=%0d key=%0d:%h vs=%0d -> x=%0d y=%0d promo=%0d act=%0d cur=%0d blink=%0d done=%0d alive=%0d",
             tx, mv, col, row, cap, kv, kc, vs, offsetX, offsetY, promotion, promo_active,
             cursor, cursor_blink, promo_done, pawn_alive);
    pawn_move_valid = 1'b0;
    pawn_captured = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic idle(input bit vs);
    apply(1'b0, 0, 0, 1'b0, 1'b0, 8'h00, vs);
  endtask

  task automatic do_reset();
    pawn_move_valid = 1'b0; pawn_captured = 1'b0; key_valid = 1'b0; vsync = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (offsetX !== 10'd265) begin failures++; $display("FAIL reset_x got=%0d exp=265", offsetX); end
    checks++; if (offsetY !== 10'd350) begin failures++; $display("FAIL reset_y got=%0d exp=350", offsetY); end
    checks++; if (promotion !== 3'd0) begin failures++; $display("FAIL reset_promo got=%0d exp=0", promotion); end
    checks++; if (pawn_alive !== 1'b1) begin failures++; $display("FAIL reset_alive got=%0d exp=1", pawn_alive); end
    checks++; if (promo_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%0d exp=0", promo_active); end
    checks++; if (cursor !== 3'd1) begin failures++; $display("FAIL reset_cursor got=%0d exp=1", cursor); end
    checks++; if (cursor_blink !== 1'b0) begin failures++; $display("FAIL reset_blink got=%0d exp=0", cursor_blink); end
    checks++; if (promo_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0d exp=0", promo_done); end
  endtask

  task automatic test_moves();
    apply(1'b1, 3, 5, 1'b0, 1'b1, K_E, 1'b1);
    checks++; if (offsetY !== 10'd295) begin failures++; $display("FAIL move1_y got=%0d exp=295", offsetY); end
    checks++; if (promo_active !== 1'b0) begin failures++; $display("FAIL move1_active got=%0d exp=0", promo_active); end
    apply(1'b1, 3, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (offsetY !== 10'd20) begin failures++; $display("FAIL move2_y got=%0d exp=20", offsetY); end
    checks++; if (offsetX !== 10'(exp_x())) begin failures++; $display("FAIL move2_x got=%0d exp=%0d", offsetX, exp_x()); end
    checks++; if (promo_active !== 1'b1) begin failures++; $display("FAIL menu_active got=%0d exp=1", promo_active); end
    checks++; if (cursor !== 3'd1) begin failures++; $display("FAIL menu_cursor got=%0d exp=1", cursor); end
    checks++; if (cursor_blink !== 1'b1) begin failures++; $display("FAIL menu_blink got=%0d exp=1", cursor_blink); end
    apply(1'b1, 6, 4, 1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (offsetY !== 10'd20) begin failures++; $display("FAIL menu_move_ignored got=%0d exp=20", offsetY); end
  endtask

  task automatic test_menu_left();
    apply(1'b0, 0, 0, 1'b0, 1'b1, K_L, 1'b1);
    checks++; if (cursor !== 3'd4) begin failures++; $display("FAIL left1_cursor got=%0d exp=4", cursor); end
    apply(1'b0, 0, 0, 1'b0, 1'b1, K_L, 1'b1);
    checks++; if (cursor !== 3'd3) begin failures++; $display("FAIL left2_cursor got=%0d exp=3", cursor); end
    apply(1'b0, 0, 0, 1'b0, 1'b1, 8'h04, 1'b1);
    checks++; if (cursor !== 3'd3) begin failures++; $display("FAIL other_key got=%0d exp=3", cursor); end
    apply(1'b0, 0, 0, 1'b0, 1'b1, K_E, 1'b1);
    checks++; if (promotion !== 3'd3) begin failures++; $display("FAIL enter_promo got=%0d exp=3", promotion); end
    checks++; if (promo_done !== 1'b1) begin failures++; $display("FAIL enter_done got=%0d exp=1", promo_done); end
    checks++; if (promo_active !== 1'b0) begin failures++; $display("FAIL enter_active got=%0d exp=0", promo_active); end
    idle(1'b1);
    checks++; if (promo_done !== 1'b0) begin failures++; $display("FAIL done_single got=%0d exp=0", promo_done); end
    apply(1'b1, 2, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (offsetX !== 10'd210) begin failures++; $display("FAIL promoted_x got=%0d exp=210", offsetX); end
    checks++; if (promotion !== 3'd3) begin failures++; $display("FAIL promoted_hold got=%0d exp=3", promotion); end
    checks++; if (promo_active !== 1'b0) begin failures++; $display("FAIL promoted_noreopen got=%0d exp=0", promo_active); end
  endtask

  task automatic test_blink();
    do_reset();
    apply(1'b1, 3, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int t = 1; t <= 30; t++) begin
      idle(1'b0);
      checks++;
      if (cursor_blink !== exp_blink()) begin
        failures++; $display("FAIL blink_tick%0d got=%0d exp=%0d", t, cursor_blink, exp_blink());
      end
      if (t == 15) begin
        checks++; if (cursor_blink !== 1'b0) begin failures++; $display("FAIL blink_t15 got=%0d exp=0", cursor_blink); end
      end
      if (t == 30) begin
        checks++; if (cursor_blink !== 1'b1) begin failures++; $display("FAIL blink_t30 got=%0d exp=1", cursor_blink); end
      end
      idle(1'b1);
    end
    repeat (40) idle(1'b1);
    checks++; if (cursor_blink !== 1'b1) begin failures++; $display("FAIL blink_hold got=%0d exp=1", cursor_blink); end
    // Enter together with a frame tick: enter takes the cycle.
    apply(1'b0, 0, 0, 1'b0, 1'b1, K_E, 1'b0);
    checks++; if (promo_done !== 1'b1) begin failures++; $display("FAIL enter_tick_done got=%0d exp=1", promo_done); end
    checks++; if (cursor_blink !== 1'b0) begin failures++; $display("FAIL enter_tick_blink got=%0d exp=0", cursor_blink); end
    checks++; if (promotion !== 3'd1) begin failures++; $display("FAIL enter_tick_promo got=%0d exp=1", promotion); end
    idle(1'b1);
  endtask

  task automatic test_capture_enter();
    do_reset();
    apply(1'b1, 3, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    apply(1'b0, 0, 0, 1'b0, 1'b1, K_R, 1'b1);
    apply(1'b0, 0, 0, 1'b1, 1'b1, K_E, 1'b1);
    checks++; if (pawn_alive !== 1'b0) begin failures++; $display("FAIL cap_alive got=%0d exp=0", pawn_alive); end
    checks++; if (promotion !== 3'd0) begin failures++; $display("FAIL cap_promo got=%0d exp=0", promotion); end
    checks++; if (promo_done !== 1'b0) begin failures++; $display("FAIL cap_done got=%0d exp=0", promo_done); end
    checks++; if (promo_active !== 1'b0) begin failures++; $display("FAIL cap_active got=%0d exp=0", promo_active); end
    apply(1'b1, 5, 5, 1'b0, 1'b1, K_E, 1'b0);
    apply(1'b1, 0, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (offsetX !== 10'd265) begin failures++; $display("FAIL dead_x got=%0d exp=265", offsetX); end
    checks++; if (offsetY !== 10'd20) begin failures++; $display("FAIL dead_y got=%0d exp=20", offsetY); end
    checks++; if (promo_done !== 1'b0) begin failures++; $display("FAIL dead_done got=%0d exp=0", promo_done); end
  endtask

`ifdef WPAWN_PROMO_TIMEOUT_EN
  task automatic test_timeout();
    int pulses;
    pulses = 0;
    do_reset();
    apply(1'b1, 3, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    apply(1'b0, 0, 0, 1'b0, 1'b1, K_R, 1'b1);
    checks++; if (cursor !== 3'd2) begin failures++; $display("FAIL to_cursor got=%0d exp=2", cursor); end
    for (int t = 1; t <= 4; t++) begin
      idle(1'b0);
      if (promo_done === 1'b1) pulses++;
      if (t < 4) begin
        checks++; if (promo_active !== 1'b1) begin failures++; $display("FAIL to_early_t%0d got=%0d exp=1", t, promo_active); end
      end
      idle(1'b1);
      if (promo_done === 1'b1) pulses++;
    end
    checks++; if (promotion !== 3'd1) begin failures++; $display("FAIL to_promo got=%0d exp=1", promotion); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL to_done_pulses got=%0d exp=1", pulses); end
    checks++; if (promo_active !== 1'b0) begin failures++; $display("FAIL to_active got=%0d exp=0", promo_active); end
  endtask
`endif

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        bit mv, cap, kv, vs;
        int col, row, ksel;
        logic [7:0] kc;
        mv  = ($urandom_range(0, 5) == 0);
        col = $urandom_range(0, 7);
        row = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 7);
        cap = ($urandom_range(0, 99) == 0);
        kv  = ($urandom_range(0, 3) == 0);
        ksel = $urandom_range(0, 3);
        kc  = (ksel == 0) ? K_R : (ksel == 1) ? K_L : (ksel == 2) ? K_E : 8'(($urandom_range(0, 255)));
        if (ksel == 2 && $urandom_range(0, 2) != 0) kc = K_R;
        vs  = $urandom_range(0, 1) == 1;
        apply(mv, col, row, cap, kv, kc, vs);
        checks++;
        if (offsetX !== 10'(exp_x()) || offsetY !== 10'(exp_y())) begin
          failures++; $display("FAIL rnd_offset got=%0d,%0d exp=%0d,%0d", offsetX, offsetY, exp_x(), exp_y());
        end
        checks++;
        if (promotion !== 3'(m_promo) || promo_done !== m_done) begin
          failures++; $display("FAIL rnd_promo got=%0d/%0d exp=%0d/%0d", promotion, promo_done, m_promo, m_done);
        end
        checks++;
        if (promo_active !== (m_mode == M_MENU) || pawn_alive !== m_alive || cursor !== 3'(m_cursor)) begin
          failures++; $display("FAIL rnd_status got=act%0d alive%0d cur%0d exp=act%0d alive%0d cur%0d",
                               promo_active, pawn_alive, cursor, (m_mode == M_MENU), m_alive, m_cursor);
        end
        if (m_mode != M_DEAD) begin
          checks++;
          if (cursor_blink !== exp_blink()) begin
            failures++; $display("FAIL rnd_blink got=%0d exp=%0d", cursor_blink, exp_blink());
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_moves();
    test_menu_left();
    test_blink();
    test_capture_enter();
`ifdef WPAWN_PROMO_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wpawn_promo_ctrl.md
Name: wpawn_promo_ctrl

Overview:
- Per-pawn position and promotion controller; sits directly upstream of the white-pawn sprite renderer.
- Drives that renderer's offsetX, offsetY and promotion inputs.
- Tracks the pawn's board square from committed moves.
- On arrival at the back rank, runs a keyboard-driven promotion menu with a frame-rate cursor blink, then latches the chosen piece code.
- One instance per white pawn.

Parameters:
- INIT_COL, 0, starting file (0..7).
- INIT_ROW, 6, starting rank; row 0 is the top (promotion) rank.
- BOARD_X0, 100, pixel X of square column 0.
- BOARD_Y0, 20, pixel Y of square row 0.
- SQ, 55, square pitch in pixels (equals sprite size).
- BLINK_FRAMES, 15, frame ticks per cursor_blink toggle.
- TIMEOUT_FRAMES, 600, menu timeout in frames (only with the optional feature).

Ports:
- vga_clk  input  1  pixel clock; all state on posedge.
- reset_n  input  1  asynchronous active-low reset.
- vsync  input  1  active-low VGA vertical sync; its falling edge is the frame tick.
- pawn_move_valid  input  1  one-cycle pulse: a move of this pawn is committed.
- pawn_col  input  3  destination file, sampled with pawn_move_valid.
- pawn_row  input  3  destination rank, sampled with pawn_move_valid.
- pawn_captured  input  1  one-cycle pulse: this pawn is removed.
- key_valid  input  1  one-cycle pulse qualifying keycode.
- keycode  input  8  HID code: 0x4F right, 0x50 left, 0x28 enter; all others ignored.
- offsetX  output  10  sprite X origin.
- offsetY  output  10  sprite Y origin.
- promotion  output  3  piece code: 0 pawn, 1 queen, 2 knight, 3 rook, 4 bishop.
- promo_active  output  1  menu open.
- cursor  output  3  highlighted choice, 1..4 (same coding as promotion).
- cursor_blink  output  1  highlight phase.
- promo_done  output  1  one-cycle pulse when a choice is latched.
- pawn_alive  output  1  0 once captured.

Behaviour:
- Reset values (async, reset_n low):
  - offsetX = BOARD_X0 + INIT_COL*SQ; offsetY = BOARD_Y0 + INIT_ROW*SQ.
  - promotion = 0, promo_active = 0, cursor = 1, cursor_blink = 0, promo_done = 0, pawn_alive = 1.
  - State IDLE; frame and blink counters = 0; vsync history register = 1.
- Frame tick: vsync_q is vsync registered each cycle; tick = vsync_q & ~vsync.
- Offset arithmetic: col*SQ and row*SQ computed at 10 bits; defaults give maximum 485/405 with no overflow. All outputs are registered.
- States:
  - IDLE:
    - pawn_move_valid: offsets update on that edge, visible next cycle.
    - If pawn_row == 0 and promotion == 0: go to MENU. cursor = 1, cursor_blink = 1, blink counter = 0; promo_active is high next cycle.
    - key_valid in the same cycle is ignored.
  - MENU:
    - pawn_move_valid is ignored.
    - Right: cursor 1→2→3→4→1. Left: cursor 4→3→2→1→4.
    - Each frame tick increments the blink counter. At BLINK_FRAMES-1 the counter clears and cursor_blink toggles.
    - Enter: promotion = cursor, promo_active = 0, cursor_blink = 0, promo_done = 1 for exactly one cycle; go to PROMOTED. Enter wins over a simultaneous frame tick.
  - PROMOTED:
    - pawn_move_valid updates offsets only. The row-0 check is disabled; promotion is held.
    - Keys are ignored.
  - DEAD:
    - pawn_alive = 0, promo_active = 0; offsets and promotion frozen; all inputs ignored until reset.
- pawn_captured moves any state to DEAD. It has priority over move, key and tick in the same cycle; an in-progress menu is abandoned with promotion unchanged.
- Reset mid-menu returns to the IDLE reset values above.

Optional Feature:
- Macro: WPAWN_PROMO_TIMEOUT_EN.
- Defined:
  - A 10-bit frame counter clears on MENU entry and increments on each tick while in MENU.
  - When it reaches TIMEOUT_FRAMES-1 on a tick, the block auto-confirms queen: promotion = 1 regardless of cursor, promo_done pulses, state goes to PROMOTED.
  - Enter in the same cycle wins and latches cursor.
- Undefined: no counter; MENU waits indefinitely for enter.

Test Plan:
- Reset, defaults (INIT_COL=3) -> offsetX = 265, offsetY = 350, promotion = 0, pawn_alive = 1, promo_active = 0.
- Move to (3,5), then (3,0) -> offsetY = 295, then 20; promo_active = 1 and cursor = 1 one cycle after the second pulse.
- In MENU, send left, left, enter -> cursor 4, then 3; promotion = 3 and a single-cycle promo_done; a later move to (2,0) keeps promotion = 3 with promo_active = 0.
- In MENU, 30 vsync falling edges (BLINK_FRAMES=15) -> cursor_blink goes 1→0 after tick 15 and 0→1 after tick 30; vsync held high produces no toggles.
- pawn_captured in the same cycle as enter in MENU -> pawn_alive = 0, promotion = 0, no promo_done; later moves leave offsets frozen.
- With WPAWN_PROMO_TIMEOUT_EN and TIMEOUT_FRAMES=4, cursor moved to 2, no enter -> on the 4th tick promotion = 1 and promo_done pulses once.
